// File: rtl/cpu_pkg.sv
// Shared decode types for the 5-stage core: ALU opcodes, ID/EX control bundle
// and the register index that never carries a real dependency.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    memtoreg;
    logic    branch;
    logic    alu_src;
    alu_op_t alu_op;
  } id_ex_ctrl_t;

  // A bubble must not write, access memory or branch, so every control bit is 0.
  localparam id_ex_ctrl_t CTRL_BUBBLE = '{
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0,
    branch:   1'b0,
    alu_src:  1'b0,
    alu_op:   ALU_ADD
  };

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX -> EX bus: decoded fields in, registered fields and hazard
// status out. The master is the surrounding pipeline, the slave is the stage.
interface id_ex_stage_if #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 32
);

  logic                   id_valid;
  logic [XLEN-1:0]        id_pc;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic [4:0]             id_rd;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic [XLEN-1:0]        id_rs1_data;
  logic [XLEN-1:0]        id_rs2_data;
  logic [XLEN-1:0]        id_imm;
  logic [3:0]             id_alu_op;
  logic                   id_alu_src;
  logic                   id_regwrite;
  logic                   id_memread;
  logic                   id_memwrite;
  logic                   id_memtoreg;
  logic                   id_branch;
  logic                   flush;
  logic                   ex_stall;

  logic                   id_ex_valid;
  logic [XLEN-1:0]        id_ex_pc;
  logic [XLEN-1:0]        id_ex_rs1_data;
  logic [XLEN-1:0]        id_ex_rs2_data;
  logic [XLEN-1:0]        id_ex_imm;
  logic [4:0]             id_ex_rs1;
  logic [4:0]             id_ex_rs2;
  logic [4:0]             id_ex_rd;
  logic [3:0]             id_ex_alu_op;
  logic                   id_ex_alu_src;
  logic                   id_ex_regwrite;
  logic                   id_ex_memread;
  logic                   id_ex_memwrite;
  logic                   id_ex_memtoreg;
  logic                   id_ex_branch;
  logic                   load_use_stall;
  logic                   id_hold;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_alu_src,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch,
           flush, ex_stall,
    input  id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_alu_op, id_ex_alu_src,
           id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg,
           id_ex_branch, load_use_stall, id_hold, stall_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_alu_src,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch,
           flush, ex_stall,
    output id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_alu_op, id_ex_alu_src,
           id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg,
           id_ex_branch, load_use_stall, id_hold, stall_count
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard compare: a load sitting in EX whose destination is read by
// the instruction in ID. Kept separate so branch-in-ID logic can reuse it.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hazard
);

  // x0 never carries a dependency, and unused operand fields are ignored.
  assign hazard = ex_valid & ex_memread & (ex_rd != REG_X0) & id_valid &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                   (id_uses_rs2 & (id_rs2 == ex_rd)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, upstream hold
// request and a saturating count of load-use bubbles.
module id_ex_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 32
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  import cpu_pkg::*;

  logic                   valid_q;
  id_ex_ctrl_t            ctrl_q;
  logic [XLEN-1:0]        pc_q;
  logic [XLEN-1:0]        rs1_data_q;
  logic [XLEN-1:0]        rs2_data_q;
  logic [XLEN-1:0]        imm_q;
  logic [4:0]             rs1_q;
  logic [4:0]             rs2_q;
  logic [4:0]             rd_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic                   hazard;
  logic                   load_en;
  logic                   insert_bubble;
  logic                   count_en;
  id_ex_ctrl_t            id_ctrl;

  load_use_detect u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_memread  (ctrl_q.memread),
    .ex_rd       (rd_q),
    .id_valid    (bus.id_valid),
    .id_uses_rs1 (bus.id_uses_rs1),
    .id_uses_rs2 (bus.id_uses_rs2),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .hazard      (hazard)
  );

  // Bundle ID control; an empty ID slot still flows through but cannot act.
  always_comb begin
    id_ctrl = CTRL_BUBBLE;
    if (bus.id_valid) begin
      id_ctrl.regwrite = bus.id_regwrite;
      id_ctrl.memread  = bus.id_memread;
      id_ctrl.memwrite = bus.id_memwrite;
      id_ctrl.memtoreg = bus.id_memtoreg;
      id_ctrl.branch   = bus.id_branch;
      id_ctrl.alu_src  = bus.id_alu_src;
      id_ctrl.alu_op   = alu_op_t'(bus.id_alu_op);
    end
  end

  // Edge priority: flush beats the downstream hold, which beats a load-use bubble.
  always_comb begin
    load_en       = bus.flush | ~bus.ex_stall;
    insert_bubble = bus.flush | hazard;
    count_en      = ~bus.flush & ~bus.ex_stall & hazard;
  end

  // Pipeline register: load a bubble or the ID fields, or hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_BUBBLE;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= REG_X0;
      rs2_q      <= REG_X0;
      rd_q       <= REG_X0;
    end else if (load_en) begin
      if (insert_bubble) begin
        valid_q    <= 1'b0;
        ctrl_q     <= CTRL_BUBBLE;
        pc_q       <= '0;
        rs1_data_q <= '0;
        rs2_data_q <= '0;
        imm_q      <= '0;
        rs1_q      <= REG_X0;
        rs2_q      <= REG_X0;
        rd_q       <= REG_X0;
      end else begin
        valid_q    <= bus.id_valid;
        ctrl_q     <= id_ctrl;
        pc_q       <= bus.id_pc;
        rs1_data_q <= bus.id_rs1_data;
        rs2_data_q <= bus.id_rs2_data;
        imm_q      <= bus.id_imm;
        rs1_q      <= bus.id_rs1;
        rs2_q      <= bus.id_rs2;
        rd_q       <= bus.id_rd;
      end
    end
  end

  // Count load-use bubbles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (count_en && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign bus.load_use_stall = hazard;
  assign bus.id_hold        = bus.ex_stall | (hazard & ~bus.flush);
  assign bus.stall_count    = stall_cnt_q;

  assign bus.id_ex_valid    = valid_q;
  assign bus.id_ex_pc       = pc_q;
  assign bus.id_ex_rs1_data = rs1_data_q;
  assign bus.id_ex_rs2_data = rs2_data_q;
  assign bus.id_ex_imm      = imm_q;
  assign bus.id_ex_rs1      = rs1_q;
  assign bus.id_ex_rs2      = rs2_q;
  assign bus.id_ex_rd       = rd_q;
  assign bus.id_ex_alu_op   = ctrl_q.alu_op;
  assign bus.id_ex_alu_src  = ctrl_q.alu_src;
  assign bus.id_ex_regwrite = ctrl_q.regwrite;
  assign bus.id_ex_memread  = ctrl_q.memread;
  assign bus.id_ex_memwrite = ctrl_q.memwrite;
  assign bus.id_ex_memtoreg = ctrl_q.memtoreg;
  assign bus.id_ex_branch   = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a reference model predicts each edge, expectations
// go through a scoreboard queue, and directed checks pin the key scenarios.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int CW   = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        branch;
    logic        flush;
    logic        ex_stall;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        branch;
  } regs_t;

  typedef struct packed {
    regs_t          regs;
    logic [CW-1:0]  cnt;
  } sb_entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  regs_t         model_regs = '0;
  logic [CW-1:0] model_cnt  = '0;
  sb_entry_t     sb_q[$];
  logic          dut_lus;
  logic          dut_hold;

  id_ex_stage_if #(.XLEN(XLEN), .STALL_CNT_W(CW)) bus ();

  id_ex_stage #(.XLEN(XLEN), .STALL_CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic regs_t sample_regs();
    regs_t r;
    r.valid    = bus.id_ex_valid;
    r.pc       = bus.id_ex_pc;
    r.rs1      = bus.id_ex_rs1;
    r.rs2      = bus.id_ex_rs2;
    r.rd       = bus.id_ex_rd;
    r.rs1_data = bus.id_ex_rs1_data;
    r.rs2_data = bus.id_ex_rs2_data;
    r.imm      = bus.id_ex_imm;
    r.alu_op   = bus.id_ex_alu_op;
    r.alu_src  = bus.id_ex_alu_src;
    r.regwrite = bus.id_ex_regwrite;
    r.memread  = bus.id_ex_memread;
    r.memwrite = bus.id_ex_memwrite;
    r.memtoreg = bus.id_ex_memtoreg;
    r.branch   = bus.id_ex_branch;
    return r;
  endfunction

  function automatic stim_t alu_instr(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] pc);
    stim_t s;
    s          = '0;
    s.valid    = 1'b1;
    s.pc       = pc;
    s.rs1      = rs1;
    s.rs2      = rs2;
    s.rd       = rd;
    s.uses_rs1 = 1'b1;
    s.uses_rs2 = 1'b1;
    s.rs1_data = 32'hA5A5_0000 | {27'd0, rs1};
    s.rs2_data = 32'h5A5A_0000 | {27'd0, rs2};
    s.imm      = pc + 32'd4;
    s.alu_op   = 4'd1;
    s.regwrite = 1'b1;
    return s;
  endfunction

  function automatic stim_t load_instr(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [31:0] pc);
    stim_t s;
    s          = '0;
    s.valid    = 1'b1;
    s.pc       = pc;
    s.rs1      = rs1;
    s.rd       = rd;
    s.uses_rs1 = 1'b1;
    s.rs1_data = 32'h0000_1000;
    s.imm      = 32'd8;
    s.alu_src  = 1'b1;
    s.regwrite = 1'b1;
    s.memread  = 1'b1;
    s.memtoreg = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.id_valid    = s.valid;
    bus.id_pc       = s.pc;
    bus.id_rs1      = s.rs1;
    bus.id_rs2      = s.rs2;
    bus.id_rd       = s.rd;
    bus.id_uses_rs1 = s.uses_rs1;
    bus.id_uses_rs2 = s.uses_rs2;
    bus.id_rs1_data = s.rs1_data;
    bus.id_rs2_data = s.rs2_data;
    bus.id_imm      = s.imm;
    bus.id_alu_op   = s.alu_op;
    bus.id_alu_src  = s.alu_src;
    bus.id_regwrite = s.regwrite;
    bus.id_memread  = s.memread;
    bus.id_memwrite = s.memwrite;
    bus.id_memtoreg = s.memtoreg;
    bus.id_branch   = s.branch;
    bus.flush       = s.flush;
    bus.ex_stall    = s.ex_stall;
  endtask

  // One cycle: drive, check the hazard flags, predict the edge, then compare.
  task automatic applyStimulus(input stim_t s);
    logic      exp_lus;
    logic      exp_hold;
    regs_t     cap;
    sb_entry_t e;
    @(negedge clk);
    drive(s);
    #1;
    exp_lus  = model_regs.valid & model_regs.memread & (model_regs.rd != 5'd0) & s.valid &
               ((s.uses_rs1 & (s.rs1 == model_regs.rd)) | (s.uses_rs2 & (s.rs2 == model_regs.rd)));
    exp_hold = s.ex_stall | (exp_lus & ~s.flush);
    dut_lus  = bus.load_use_stall;
    dut_hold = bus.id_hold;
    checkOutput("load_use_stall", 256'(dut_lus), 256'(exp_lus));
    checkOutput("id_hold", 256'(dut_hold), 256'(exp_hold));
    if (s.flush) begin
      model_regs = '0;
    end else if (s.ex_stall) begin
      model_regs = model_regs;
    end else if (exp_lus) begin
      model_regs = '0;
      if (model_cnt != {CW{1'b1}}) model_cnt = model_cnt + 1'b1;
    end else begin
      cap          = '0;
      cap.valid    = s.valid;
      cap.pc       = s.pc;
      cap.rs1      = s.rs1;
      cap.rs2      = s.rs2;
      cap.rd       = s.rd;
      cap.rs1_data = s.rs1_data;
      cap.rs2_data = s.rs2_data;
      cap.imm      = s.imm;
      if (s.valid) begin
        cap.alu_op   = s.alu_op;
        cap.alu_src  = s.alu_src;
        cap.regwrite = s.regwrite;
        cap.memread  = s.memread;
        cap.memwrite = s.memwrite;
        cap.memtoreg = s.memtoreg;
        cap.branch   = s.branch;
      end
      model_regs = cap;
    end
    sb_q.push_back('{regs: model_regs, cnt: model_cnt});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      checkOutput("regs", 256'(sample_regs()), 256'(e.regs));
      checkOutput("stall_count", 256'(bus.stall_count), 256'(e.cnt));
    end
  endtask

  initial begin
    stim_t s;
    drive('0);

    // Reset state
    #12;
    checkOutput("reset_regs", 256'(sample_regs()), 256'd0);
    checkOutput("reset_cnt", 256'(bus.stall_count), 256'd0);
    @(negedge clk);
    rst = 1'b0;

    // Normal capture
    s = alu_instr(5'd3, 5'd1, 5'd2, 32'h100);
    s.rs1_data = 32'h11;
    applyStimulus(s);
    checkOutput("norm_rs1", 256'(bus.id_ex_rs1), 256'd1);
    checkOutput("norm_rd", 256'(bus.id_ex_rd), 256'd3);
    checkOutput("norm_rs1_data", 256'(bus.id_ex_rs1_data), 256'h11);
    checkOutput("norm_valid", 256'(bus.id_ex_valid), 256'd1);
    checkOutput("norm_lus", 256'(dut_lus), 256'd0);

    // Load-use: lw x5 then a consumer of x5 through rs2
    applyStimulus(load_instr(5'd5, 5'd1, 32'h104));
    s = alu_instr(5'd8, 5'd6, 5'd5, 32'h108);
    applyStimulus(s);
    checkOutput("lu_flag", 256'(dut_lus), 256'd1);
    checkOutput("lu_hold", 256'(dut_hold), 256'd1);
    checkOutput("lu_bubble_valid", 256'(bus.id_ex_valid), 256'd0);
    checkOutput("lu_bubble_rd", 256'(bus.id_ex_rd), 256'd0);
    checkOutput("lu_cnt", 256'(bus.stall_count), 256'd1);
    applyStimulus(s);
    checkOutput("lu_retry_lus", 256'(dut_lus), 256'd0);
    checkOutput("lu_enter_valid", 256'(bus.id_ex_valid), 256'd1);
    checkOutput("lu_enter_rd", 256'(bus.id_ex_rd), 256'd8);

    // x0 and unused operands never stall
    applyStimulus(load_instr(5'd0, 5'd1, 32'h10C));
    applyStimulus(alu_instr(5'd9, 5'd0, 5'd2, 32'h110));
    checkOutput("x0_no_stall", 256'(dut_lus), 256'd0);
    applyStimulus(load_instr(5'd7, 5'd1, 32'h114));
    s = alu_instr(5'd9, 5'd7, 5'd9, 32'h118);
    s.uses_rs1 = 1'b0;
    applyStimulus(s);
    checkOutput("unused_no_stall", 256'(dut_lus), 256'd0);

    // Flush wins over ex_stall and a load-use hazard
    applyStimulus(load_instr(5'd4, 5'd1, 32'h11C));
    s = alu_instr(5'd9, 5'd4, 5'd2, 32'h120);
    s.flush    = 1'b1;
    s.ex_stall = 1'b1;
    applyStimulus(s);
    checkOutput("flush_lus", 256'(dut_lus), 256'd1);
    checkOutput("flush_hold", 256'(dut_hold), 256'd1);
    checkOutput("flush_valid", 256'(bus.id_ex_valid), 256'd0);
    checkOutput("flush_cnt", 256'(bus.stall_count), 256'd1);

    // ex_stall freezes the register while ID keeps changing
    applyStimulus(alu_instr(5'd10, 5'd1, 5'd2, 32'h200));
    for (int i = 0; i < 3; i++) begin
      s = alu_instr(5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), $urandom);
      s.rs1_data = $urandom;
      s.alu_op   = 4'($urandom_range(0, 10));
      s.ex_stall = 1'b1;
      applyStimulus(s);
      checkOutput("stall_pc", 256'(bus.id_ex_pc), 256'h200);
      checkOutput("stall_rd", 256'(bus.id_ex_rd), 256'd10);
    end
    applyStimulus(alu_instr(5'd11, 5'd3, 5'd4, 32'h300));
    checkOutput("release_pc", 256'(bus.id_ex_pc), 256'h300);
    checkOutput("release_rd", 256'(bus.id_ex_rd), 256'd11);

    // Asynchronous reset in the middle of a cycle
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_regs", 256'(sample_regs()), 256'd0);
    checkOutput("async_rst_cnt", 256'(bus.stall_count), 256'd0);
    model_regs = '0;
    model_cnt  = '0;
    @(negedge clk);
    rst = 1'b0;

    // Empty ID slot: fields flow through, control forced off
    s = load_instr(5'd12, 5'd1, 32'h400);
    s.valid = 1'b0;
    applyStimulus(s);
    checkOutput("inv_valid", 256'(bus.id_ex_valid), 256'd0);
    checkOutput("inv_regwrite", 256'(bus.id_ex_regwrite), 256'd0);
    checkOutput("inv_memread", 256'(bus.id_ex_memread), 256'd0);
    checkOutput("inv_rd", 256'(bus.id_ex_rd), 256'd12);

    // Five load-use bubbles saturate a 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      applyStimulus(load_instr(5'd5, 5'd1, 32'h500 + 32'(i * 16)));
      s = alu_instr(5'd6, 5'd5, 5'd2, 32'h504 + 32'(i * 16));
      applyStimulus(s);
      applyStimulus(s);
    end
    checkOutput("sat_cnt", 256'(bus.stall_count), 256'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage core, with built-in load-use hazard detection.
- Captures decoded instruction fields and register-file operands from ID. Presents them to EX and to forward_unit (id_ex_rs1/id_ex_rs2).
- Requests an upstream hold (PC, IF/ID) when a load in EX feeds the instruction in ID, and inserts a bubble.
- Honours branch flush from EX and a hold from downstream multi-cycle units.

Parameters:
XLEN, 32, datapath width of PC, operands, immediate
STALL_CNT_W, 32, width of saturating load-use stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
id_imm  in  XLEN  decoded immediate
id_alu_op  in  4  ALU operation select
id_alu_src  in  1  0=rs2, 1=imm
id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch  in  1 each  control
flush  in  1  branch/jump taken in EX; kill ID instruction
ex_stall  in  1  downstream hold; freeze ID/EX
id_ex_valid  out  1  registered valid
id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  out  XLEN each  registered fields
id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  registered indices (to forward_unit)
id_ex_alu_op  out  4; id_ex_alu_src, id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_branch  out  1 each
load_use_stall  out  1  combinational load-use hazard flag
id_hold  out  1  combinational: hold PC and IF/ID this cycle
stall_count  out  STALL_CNT_W  saturating count of load-use bubble cycles

Behaviour:
- Reset (async, rst=1): all registered outputs 0, i.e. a bubble. stall_count=0. Applies immediately mid-operation.
- Hazard: load_use_stall = id_ex_valid & id_ex_memread & (id_ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==id_ex_rd) | (id_uses_rs2 & id_rs2==id_ex_rd)).
- id_hold = ex_stall | (load_use_stall & ~flush).
- Per-edge priority (rst excepted):
  - 1. flush=1 → load bubble, even if ex_stall=1. Flush wins.
  - 2. ex_stall=1 → hold all registers unchanged.
  - 3. load_use_stall=1 → load bubble. ID is held upstream and re-presented next cycle.
  - 4. Otherwise → capture all id_* fields; id_ex_valid=id_valid.
- Bubble: valid, all control bits, rs1, rs2, rd, alu_op = 0; pc/data/imm = 0. forward_unit therefore sees x0 and never forwards.
- After one load-use bubble, id_ex_memread=0, so the hazard clears. The instruction enters next cycle with exactly 1 bubble cycle.
- id_valid=0 with no hazard captures fields with valid=0 and control forced to 0.
- stall_count increments by 1 on edges where priority 3 is taken. It saturates at all-ones with no wrap, and is untouched by flush/ex_stall.
- Latency: ID→EX is 1 cycle; outputs are registered.

Decomposition:
- Shared package cpu_pkg:
  - alu_op_t (4-bit enum)
  - id_ex_ctrl_t packed struct {regwrite, memread, memwrite, memtoreg, branch, alu_src, alu_op}
  - CTRL_BUBBLE constant
  - REG_X0 = 5'd0
- Sub-module load_use_detect (combinational hazard compare), reused by future branch-in-ID logic. The register and counter stay in id_ex_stage.

Test Plan:
- Normal capture: id_valid=1, rs1=1, rs2=2, rd=3, regwrite=1, rs1_data=0x11 → next edge id_ex_rs1=1, id_ex_rd=3, id_ex_rs1_data=0x11, valid=1, load_use_stall=0.
- Load-use:
  - Stimulus: EX holds lw rd=5 (memread=1); ID has rs2=5, uses_rs2=1.
  - Response: load_use_stall=1 and id_hold=1. Next edge gives a bubble (valid=0, rd=0) and stall_count=1. The following edge captures the ID instruction.
- x0/unused operands: EX lw rd=0 with ID rs1=0 → no stall. EX lw rd=7 with ID rs1=7, uses_rs1=0 → no stall.
- Flush priority: flush=1 together with ex_stall=1 and a load-use hazard → bubble loaded, stall_count unchanged, id_hold=1 (from ex_stall).
- ex_stall: ex_stall=1 for 3 cycles with changing id_* inputs → all id_ex_* outputs stable. Released → the current ID fields are captured.
- Reset and saturation:
  - Async rst mid-stream → outputs 0 before the next clk edge.
  - With STALL_CNT_W=2, 5 hazard bubbles → stall_count=3.
